jpeg_capture_ctrl: RTL and testbench

Frame-level sequencer for the JPEG encoder. It arms the encoder's `start_capture_in` before each camera frame and shadows the QF and image-size configuration so it only changes between frames. It tracks the frame through encoding to `image_valid_out`, then reports completion, compressed size, frame count and timeout/empty-image errors. It sits in the `clk` domain beside the encoder and is driven by a host/register block; all encoder status inputs arrive already synchronized to `clk`.

---
 rtl/jpeg_capture_ctrl.sv | 149 ++++++++++++++
 tb/tb_jpeg_capture_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_capture_ctrl.sv
// jpeg_capture_ctrl: frame-level sequencer that arms the JPEG encoder per camera frame,
// shadows its configuration between frames and reports completion, size, count and errors.
module jpeg_capture_ctrl #(
    parameter int ARM_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 12_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start_in,
    input  logic        cmd_abort_in,
    input  logic        cfg_continuous_in,
    input  logic [1:0]  cfg_qf_in,
    input  logic [10:0] cfg_x_size_in,
    input  logic [9:0]  cfg_y_size_in,
    input  logic        frame_valid_in,
    input  logic        enc_data_valid_in,
    input  logic [15:0] enc_address_in,
    input  logic        enc_image_valid_in,
    output logic        start_capture_out,
    output logic [1:0]  qf_select_out,
    output logic [10:0] x_size_out,
    output logic [9:0]  y_size_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [16:0] image_bytes_out,
    output logic [15:0] frame_count_out,
    output logic        error_out,
    output logic [1:0]  error_code_out
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AC_W = $clog2(ARM_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BLANK, S_ARM, S_WAIT_SOF, S_CAPTURE, S_WAIT_IMG, S_DONE, S_ERROR
    } state_t;

    state_t          r_state, w_next;
    logic            r_fv, r_fv_prev, r_iv, r_iv_prev;
    logic [WD_W-1:0] r_wd;
    logic [AC_W-1:0] r_arm_cnt;
    logic [15:0]     r_last_addr;
    logic            r_seen;
    logic            r_start, r_busy, r_done, r_error;
    logic [1:0]      r_qf, r_code;
    logic [10:0]     r_x;
    logic [9:0]      r_y;
    logic [16:0]     r_bytes;
    logic [15:0]     r_count;
    logic            w_fv_rise, w_fv_fall, w_iv_rise, w_timeout, w_latch, w_track;
    logic [1:0]      w_err_code;

    // Inputs are sampled once before edge detection, so a rise acts one edge after it is seen.
    assign w_fv_rise = r_fv & ~r_fv_prev;
    assign w_fv_fall = ~r_fv & r_fv_prev;
    assign w_iv_rise = r_iv & ~r_iv_prev;
    assign w_timeout = r_wd >= WD_W'(TIMEOUT_CYCLES - 1);
    assign w_latch   = (w_next == S_WAIT_BLANK) && (r_state != S_WAIT_BLANK);
    assign w_track   = (r_state == S_CAPTURE || r_state == S_WAIT_IMG) && enc_data_valid_in;

    always_comb begin
        w_next     = r_state;
        w_err_code = 2'b01;
        case (r_state)
            S_IDLE:       w_next = cmd_start_in ? S_WAIT_BLANK : S_IDLE;
            S_WAIT_BLANK: w_next = frame_valid_in ? S_WAIT_BLANK : S_ARM;
            S_ARM:        w_next = w_fv_rise ? S_CAPTURE
                                 : (r_arm_cnt == AC_W'(ARM_CYCLES - 1)) ? S_WAIT_SOF : S_ARM;
            S_WAIT_SOF:   w_next = w_fv_rise ? S_CAPTURE : w_timeout ? S_ERROR : S_WAIT_SOF;
            S_CAPTURE:    w_next = w_fv_fall ? S_WAIT_IMG : w_timeout ? S_ERROR : S_CAPTURE;
            S_WAIT_IMG: begin
                w_next     = w_iv_rise ? (r_seen ? S_DONE : S_ERROR) : w_timeout ? S_ERROR : S_WAIT_IMG;
                w_err_code = w_iv_rise ? 2'b10 : 2'b01;
            end
            S_DONE:       w_next = cfg_continuous_in ? S_WAIT_BLANK : S_IDLE;
            default:      w_next = S_IDLE;
        endcase
        if (cmd_abort_in)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_fv        <= 1'b0;
            r_fv_prev   <= 1'b0;
            r_iv        <= 1'b0;
            r_iv_prev   <= 1'b0;
            r_wd        <= '0;
            r_arm_cnt   <= '0;
            r_last_addr <= '0;
            r_seen      <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_code      <= '0;
            r_qf        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_bytes     <= '0;
            r_count     <= '0;
        end else begin
            r_state   <= w_next;
            r_fv      <= frame_valid_in;
            r_fv_prev <= r_fv;
            r_iv      <= enc_image_valid_in;
            r_iv_prev <= r_iv;
            r_wd      <= (w_next != r_state || enc_data_valid_in) ? '0
                       : (&r_wd) ? r_wd : r_wd + 1'b1;
            r_arm_cnt <= (r_state == S_ARM && w_next == S_ARM) ? r_arm_cnt + 1'b1 : '0;
            r_start   <= w_next == S_ARM;
            r_busy    <= w_next != S_IDLE;
            r_done    <= w_next == S_DONE;
            if (w_latch) begin
                r_qf   <= cfg_qf_in;
                r_x    <= cfg_x_size_in;
                r_y    <= cfg_y_size_in;
                r_seen <= 1'b0;
            end
            if (w_latch && r_state == S_IDLE) begin
                r_error <= 1'b0;
                r_code  <= '0;
            end
            if (w_track) begin
                r_last_addr <= enc_address_in;
                r_seen      <= 1'b1;
            end
            if (w_next == S_DONE) begin
                r_count <= r_count + 16'd1;
                r_bytes <= {1'b0, r_last_addr} + 17'd4;
            end
            if (w_next == S_ERROR && r_state != S_ERROR) begin
                r_error <= 1'b1;
                r_code  <= w_err_code;
            end
        end
    end

    assign start_capture_out = r_start;
    assign qf_select_out     = r_qf;
    assign x_size_out        = r_x;
    assign y_size_out        = r_y;
    assign busy_out          = r_busy;
    assign done_out          = r_done;
    assign image_bytes_out   = r_bytes;
    assign frame_count_out   = r_count;
    assign error_out         = r_error;
    assign error_code_out    = r_code;
endmodule

// File: tb/tb_jpeg_capture_ctrl.sv
// tb_jpeg_capture_ctrl: directed bench for jpeg_capture_ctrl with ARM_CYCLES=4, TIMEOUT_CYCLES=1000.
module tb_jpeg_capture_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start_in = 1'b0, cmd_abort_in = 1'b0, cfg_continuous_in = 1'b0;
    logic [1:0]  cfg_qf_in = 2'b01;
    logic [10:0] cfg_x_size_in = 11'd640;
    logic [9:0]  cfg_y_size_in = 10'd480;
    logic        frame_valid_in = 1'b0, enc_data_valid_in = 1'b0, enc_image_valid_in = 1'b0;
    logic [15:0] enc_address_in = '0;
    logic        start_capture_out, busy_out, done_out, error_out;
    logic [1:0]  qf_select_out, error_code_out;
    logic [10:0] x_size_out;
    logic [9:0]  y_size_out;
    logic [16:0] image_bytes_out;
    logic [15:0] frame_count_out;
    int          n_vec = 0, n_err = 0;
    int          cnt;
    logic        seen;

    jpeg_capture_ctrl #(.ARM_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset),
        .cmd_start_in(cmd_start_in), .cmd_abort_in(cmd_abort_in),
        .cfg_continuous_in(cfg_continuous_in), .cfg_qf_in(cfg_qf_in),
        .cfg_x_size_in(cfg_x_size_in), .cfg_y_size_in(cfg_y_size_in),
        .frame_valid_in(frame_valid_in), .enc_data_valid_in(enc_data_valid_in),
        .enc_address_in(enc_address_in), .enc_image_valid_in(enc_image_valid_in),
        .start_capture_out(start_capture_out), .qf_select_out(qf_select_out),
        .x_size_out(x_size_out), .y_size_out(y_size_out), .busy_out(busy_out),
        .done_out(done_out), .image_bytes_out(image_bytes_out),
        .frame_count_out(frame_count_out), .error_out(error_out), .error_code_out(error_code_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd;
        cmd_start_in = 1'b1;
        tick;
        cmd_start_in = 1'b0;
    endtask

    task automatic arm_count(input string tag);
        cnt = 0;
        repeat (8) begin
            tick;
            cnt += int'(start_capture_out);
        end
        chk(tag, cnt, 4);
    endtask

    task automatic run_frame(input int len, input int ndata, input bit chg);
        frame_valid_in = 1'b1;
        for (int i = 0; i < len; i++) begin
            enc_data_valid_in = (i >= 20 && i < 20 + ndata);
            enc_address_in    = 16'((i - 20) * 4);
            if (chg && i == len / 2) cfg_qf_in = 2'b10;
            tick;
        end
        frame_valid_in    = 1'b0;
        enc_data_valid_in = 1'b0;
    endtask

    task automatic img(input int gap, input string tag);
        repeat (gap) tick;
        enc_image_valid_in = 1'b1;
        tick;
        chk({tag, "_done_early"}, done_out, 0);
        tick;
        chk({tag, "_done"}, done_out, 1);
        enc_image_valid_in = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_busy", busy_out, 0);
        chk("rst_start", start_capture_out, 0);
        chk("rst_count", frame_count_out, 0);
        chk("rst_err", {error_out, error_code_out}, 0);
        reset = 1'b0;
        tick;

        // single-shot capture
        start_cmd;
        chk("t1_busy", busy_out, 1);
        chk("t1_cfg", {qf_select_out, x_size_out, y_size_out}, {2'b01, 11'd640, 10'd480});
        arm_count("t1_arm_len");
        run_frame(200, 10, 1'b0);
        img(50, "t1");
        chk("t1_bytes", image_bytes_out, 40);
        chk("t1_count", frame_count_out, 1);
        tick;
        chk("t1_done_off", done_out, 0);
        chk("t1_idle", busy_out, 0);

        // start while a frame is already running
        frame_valid_in = 1'b1;
        tick;
        start_cmd;
        seen = 1'b0;
        repeat (6) begin
            tick;
            seen |= start_capture_out;
        end
        chk("t2_no_arm_midframe", seen, 0);
        frame_valid_in = 1'b0;
        arm_count("t2_arm_len");
        run_frame(100, 5, 1'b0);
        img(10, "t2");
        chk("t2_bytes", image_bytes_out, 20);
        chk("t2_count", frame_count_out, 2);

        // continuous mode, QF changed mid-frame 1
        tick;
        cfg_continuous_in = 1'b1;
        cfg_qf_in = 2'b00;
        start_cmd;
        chk("t3_qf_latch", qf_select_out, 0);
        repeat (8) tick;
        run_frame(100, 5, 1'b1);
        chk("t3_qf_hold_frame", qf_select_out, 0);
        img(10, "t3f1");
        chk("t3_qf_hold_done", qf_select_out, 0);
        chk("t3_count1", frame_count_out, 3);
        tick;
        chk("t3_qf_relatch", qf_select_out, 2);
        repeat (10) tick;
        run_frame(100, 5, 1'b0);
        img(10, "t3f2");
        repeat (10) tick;
        run_frame(100, 5, 1'b0);
        cfg_continuous_in = 1'b0;
        img(10, "t3f3");
        chk("t3_count3", frame_count_out, 5);
        tick;
        chk("t3_idle", busy_out, 0);

        // watchdog timeout waiting for start of frame
        start_cmd;
        repeat (1004) tick;
        chk("t4_err_early", error_out, 0);
        tick;
        chk("t4_err", {error_out, error_code_out}, {1'b1, 2'b01});
        tick;
        chk("t4_idle", busy_out, 0);
        chk("t4_count", frame_count_out, 5);

        // empty image
        start_cmd;
        chk("t5_err_clear", {error_out, error_code_out}, 0);
        repeat (8) tick;
        run_frame(100, 0, 1'b0);
        repeat (10) tick;
        enc_image_valid_in = 1'b1;
        tick;
        tick;
        chk("t5_no_done", done_out, 0);
        chk("t5_err", {error_out, error_code_out}, {1'b1, 2'b10});
        enc_image_valid_in = 1'b0;
        tick;
        chk("t5_idle", busy_out, 0);
        chk("t5_count", frame_count_out, 5);

        // abort during capture
        start_cmd;
        repeat (8) tick;
        frame_valid_in = 1'b1;
        repeat (10) tick;
        cmd_abort_in = 1'b1;
        tick;
        cmd_abort_in = 1'b0;
        chk("t6_abort_idle", busy_out, 0);
        frame_valid_in = 1'b0;
        seen = 1'b0;
        repeat (5) tick;
        enc_image_valid_in = 1'b1;
        repeat (4) begin
            tick;
            seen |= done_out;
        end
        enc_image_valid_in = 1'b0;
        chk("t6_abort_no_done", seen, 0);
        chk("t6_abort_no_err", error_out, 0);
        chk("t6_abort_count", frame_count_out, 5);

        // start and abort together in IDLE
        cmd_start_in = 1'b1;
        cmd_abort_in = 1'b1;
        tick;
        cmd_start_in = 1'b0;
        cmd_abort_in = 1'b0;
        chk("t6_start_abort", busy_out, 0);
        tick;
        chk("t6_start_abort2", busy_out, 0);

        // asynchronous reset in the middle of ARM
        start_cmd;
        tick;
        chk("t6_arming", start_capture_out, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_start", start_capture_out, 0);
        chk("t6_async_count", frame_count_out, 0);
        chk("t6_async_busy", busy_out, 0);
        tick;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
